// File: rtl/cve2_xif_mac_copro_pkg.sv
// Shared types, opcode constants and decode helpers for the X-IF multiply-accumulate coprocessor.
package cve2_xif_mac_copro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE,
    RESULT
  } xif_copro_state_e;

  typedef enum logic [1:0] {
    OP_MAC,
    OP_SWAP,
    OP_RDACC,
    OP_POPC
  } copro_op_e;

  localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

  localparam logic [2:0] F3_MAC   = 3'b000;
  localparam logic [2:0] F3_SWAP  = 3'b001;
  localparam logic [2:0] F3_RDACC = 3'b010;
  localparam logic [2:0] F3_POPC  = 3'b011;

  // Source operands each op reads; bit i stands for rs(i+1).
  function automatic logic [2:0] op_reg_read(input logic [2:0] funct3);
    logic [2:0] rr;
    rr = 3'b000;
    case (funct3)
      F3_MAC:           rr = 3'b011;
      F3_SWAP, F3_POPC: rr = 3'b001;
      F3_RDACC:         rr = 3'b000;
      default:          rr = 3'b000;
    endcase
    return rr;
  endfunction

  function automatic logic [31:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return {26'd0, cnt};
  endfunction

endpackage

// File: rtl/cve2_xif_iter_mul.sv
// Iterative unsigned 32x32 multiplier keeping the low 32 product bits; retires MulBitsPerCycle
// multiplier bits per cycle and pulses done_o together with the final product.
module cve2_xif_iter_mul #(
  parameter int unsigned MulBitsPerCycle = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        done_o,
  output logic [31:0] product_o
);

  localparam int unsigned Steps = 32 / MulBitsPerCycle;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [31:0]     p_q;
  logic [31:0]     p_next;
  logic            last_step;

  // Multiplicand moves left and multiplier moves right, so only the low slice of b_q matters.
  always_comb begin
    p_next = p_q;
    for (int unsigned i = 0; i < MulBitsPerCycle; i++) begin
      if (b_q[i]) begin
        p_next = p_next + (a_q << i);
      end
    end
  end

  assign last_step = (cnt_q == CntW'(Steps - 1));
  assign done_o    = busy_q & last_step;
  assign product_o = p_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      a_q    <= op_a_i;
      b_q    <= op_b_i;
      p_q    <= '0;
    end else if (kill_i) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      p_q   <= p_next;
      a_q   <= a_q << MulBitsPerCycle;
      b_q   <= b_q >> MulBitsPerCycle;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cve2_xif_mac_copro.sv
// CV-X-IF coprocessor for custom-0: multiply-accumulate into a private accumulator, accumulator
// swap/read and popcount, returning results through the X-IF result port.
module cve2_xif_mac_copro
  import cve2_xif_mac_copro_pkg::*;
#(
  parameter int unsigned MulBitsPerCycle = 4,
  parameter logic [6:0]  CustomOpcode    = CUSTOM0_OPCODE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        xif_issue_valid_i,
  input  logic [31:0] xif_issue_req_instr_i,
  output logic        xif_issue_ready_o,
  output logic        xif_issue_resp_accept_o,
  output logic        xif_issue_resp_writeback_o,
  output logic [2:0]  xif_issue_resp_register_read_o,
  input  logic [31:0] xif_register_rs1_i,
  input  logic [31:0] xif_register_rs2_i,
  input  logic [31:0] xif_register_rs3_i,
  input  logic [2:0]  xif_register_rs_valid_i,
  input  logic        xif_commit_valid_i,
  input  logic        xif_commit_kill_i,
  input  logic        xif_result_ready_i,
  output logic        xif_result_valid_o,
  output logic        xif_result_we_o,
  output logic [31:0] xif_result_data_o,
  output logic        busy_o
);

  // Handshakes: issue fires on valid & ready (ready only in IDLE); result fires on valid & ready,
  // and once result_valid rises it holds with stable data until the core takes it.

  xif_copro_state_e state_q;
  copro_op_e        op_q;
  copro_op_e        dec_op;
  logic [31:0]      rs1_q;
  logic [31:0]      acc_q;
  logic [31:0]      acc_new_q;
  logic [31:0]      res_q;
  logic             committed_q;

  logic [2:0]  funct3;
  logic        accept;
  logic        hs_accept;
  logic        kill_now;
  logic        commit_now;
  logic        exec_finish;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_product;
  logic [31:0] res_d;
  logic [31:0] acc_new_d;
  logic        unused_inputs;

  assign funct3 = xif_issue_req_instr_i[14:12];
  assign accept = (xif_issue_req_instr_i[6:0] == CustomOpcode) &&
                  (xif_issue_req_instr_i[31:25] == 7'd0) && !funct3[2];
  assign dec_op = copro_op_e'(funct3[1:0]);

  assign xif_issue_ready_o              = (state_q == IDLE);
  assign xif_issue_resp_accept_o        = accept;
  assign xif_issue_resp_writeback_o     = accept;
  assign xif_issue_resp_register_read_o = accept ? op_reg_read(funct3) : 3'b000;

  assign hs_accept = xif_issue_valid_i && xif_issue_ready_o && accept;

  // A commit is only meaningful until the first one has been seen for this instruction.
  assign commit_now = xif_commit_valid_i && !committed_q;
  assign kill_now   = commit_now && xif_commit_kill_i;

  assign mul_start = hs_accept && (dec_op == OP_MAC) &&
                     !(xif_commit_valid_i && xif_commit_kill_i);

  cve2_xif_iter_mul #(
    .MulBitsPerCycle(MulBitsPerCycle)
  ) u_iter_mul (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (mul_start),
    .kill_i   ((state_q == EXEC) && kill_now),
    .op_a_i   (xif_register_rs1_i),
    .op_b_i   (xif_register_rs2_i),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // Result and the pending accumulator value; the accumulator itself moves only on result handshake.
  always_comb begin
    res_d     = acc_q;
    acc_new_d = acc_q;
    case (op_q)
      OP_MAC: begin
        res_d     = acc_q + mul_product;
        acc_new_d = acc_q + mul_product;
      end
      OP_SWAP: begin
        res_d     = acc_q;
        acc_new_d = rs1_q;
      end
      OP_RDACC: res_d = acc_q;
      OP_POPC:  res_d = popcount32(rs1_q);
      default:  res_d = acc_q;
    endcase
  end

  assign exec_finish = (op_q != OP_MAC) || mul_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= OP_MAC;
      rs1_q       <= '0;
      acc_q       <= '0;
      acc_new_q   <= '0;
      res_q       <= '0;
      committed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_accept) begin
            op_q        <= dec_op;
            rs1_q       <= xif_register_rs1_i;
            committed_q <= xif_commit_valid_i && !xif_commit_kill_i;
            if (!(xif_commit_valid_i && xif_commit_kill_i)) begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          if (kill_now) begin
            state_q <= IDLE;
          end else begin
            if (commit_now) begin
              committed_q <= 1'b1;
            end
            if (exec_finish) begin
              res_q     <= res_d;
              acc_new_q <= acc_new_d;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          if (kill_now) begin
            state_q <= IDLE;
          end else if (committed_q) begin
            state_q <= RESULT;
          end else if (commit_now) begin
            committed_q <= 1'b1;
          end
        end
        RESULT: begin
          if (xif_result_ready_i) begin
            acc_q   <= acc_new_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign xif_result_valid_o = (state_q == RESULT);
  assign xif_result_we_o    = (state_q == RESULT);
  assign xif_result_data_o  = res_q;
  assign busy_o             = (state_q != IDLE);

  assign unused_inputs = ^{xif_register_rs3_i, xif_register_rs_valid_i,
                           xif_issue_req_instr_i[24:15], xif_issue_req_instr_i[11:7]};

endmodule

// File: tb/tb_cve2_xif_mac_copro.sv
// Scoreboard bench for cve2_xif_mac_copro: a reference accumulator model predicts each result.
module tb_cve2_xif_mac_copro;

  localparam int unsigned MulBits = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        xif_issue_valid_i;
  logic [31:0] xif_issue_req_instr_i;
  logic        xif_issue_ready_o;
  logic        xif_issue_resp_accept_o;
  logic        xif_issue_resp_writeback_o;
  logic [2:0]  xif_issue_resp_register_read_o;
  logic [31:0] xif_register_rs1_i;
  logic [31:0] xif_register_rs2_i;
  logic [31:0] xif_register_rs3_i;
  logic [2:0]  xif_register_rs_valid_i;
  logic        xif_commit_valid_i;
  logic        xif_commit_kill_i;
  logic        xif_result_ready_i;
  logic        xif_result_valid_o;
  logic        xif_result_we_o;
  logic [31:0] xif_result_data_o;
  logic        busy_o;

  cve2_xif_mac_copro #(
    .MulBitsPerCycle(MulBits)
  ) dut (
    .clk_i                         (clk_i),
    .rst_ni                        (rst_ni),
    .xif_issue_valid_i             (xif_issue_valid_i),
    .xif_issue_req_instr_i         (xif_issue_req_instr_i),
    .xif_issue_ready_o             (xif_issue_ready_o),
    .xif_issue_resp_accept_o       (xif_issue_resp_accept_o),
    .xif_issue_resp_writeback_o    (xif_issue_resp_writeback_o),
    .xif_issue_resp_register_read_o(xif_issue_resp_register_read_o),
    .xif_register_rs1_i            (xif_register_rs1_i),
    .xif_register_rs2_i            (xif_register_rs2_i),
    .xif_register_rs3_i            (xif_register_rs3_i),
    .xif_register_rs_valid_i       (xif_register_rs_valid_i),
    .xif_commit_valid_i            (xif_commit_valid_i),
    .xif_commit_kill_i             (xif_commit_kill_i),
    .xif_result_ready_i            (xif_result_ready_i),
    .xif_result_valid_o            (xif_result_valid_o),
    .xif_result_we_o               (xif_result_we_o),
    .xif_result_data_o             (xif_result_data_o),
    .busy_o                        (busy_o)
  );

  // Clock and cycle counter
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [31:0] acc_m;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_rr(input logic [2:0] f3);
    case (f3)
      3'b000:         return 3'b011;
      3'b001, 3'b011: return 3'b001;
      default:        return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3);
    return {7'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), f3,
            5'($urandom_range(0, 31)), 7'b0001011};
  endfunction

  // Drivers: called right after a negedge; return at the negedge following the handshake.
  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic c_now, input logic c_kill, input logic exp_acc,
                       input logic [2:0] exp_reg, output int hs_cyc);
    int guard;
    guard = 0;
    xif_issue_valid_i     = 1'b1;
    xif_issue_req_instr_i = instr;
    xif_register_rs1_i    = a;
    xif_register_rs2_i    = b;
    xif_commit_valid_i    = c_now;
    xif_commit_kill_i     = c_kill;
    #1;
    while (!xif_issue_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    check("issue_ready", {31'd0, xif_issue_ready_o}, 32'd1);
    check("issue_accept", {31'd0, xif_issue_resp_accept_o}, {31'd0, exp_acc});
    check("issue_writeback", {31'd0, xif_issue_resp_writeback_o}, {31'd0, exp_acc});
    check("issue_reg_read", {29'd0, xif_issue_resp_register_read_o}, {29'd0, exp_reg});
    @(posedge clk_i);
    hs_cyc = cyc;
    @(negedge clk_i);
    xif_issue_valid_i     = 1'b0;
    xif_issue_req_instr_i = 32'd0;
    xif_commit_valid_i    = 1'b0;
    xif_commit_kill_i     = 1'b0;
  endtask

  task automatic collect(input int hold, output int seen_cyc);
    int          guard;
    logic [31:0] exp;
    guard = 0;
    while (!xif_result_valid_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    seen_cyc = cyc;
    if (!xif_result_valid_o) begin
      check("result_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    check("result_data", xif_result_data_o, exp);
    check("result_we", {31'd0, xif_result_we_o}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("hold_valid", {31'd0, xif_result_valid_o}, 32'd1);
      check("hold_data", xif_result_data_o, exp);
    end
    xif_result_ready_i = 1'b1;
    @(negedge clk_i);
    xif_result_ready_i = 1'b0;
    check("ready_after_result", {31'd0, xif_issue_ready_o}, 32'd1);
    check("valid_after_result", {31'd0, xif_result_valid_o}, 32'd0);
    check("busy_after_result", {31'd0, busy_o}, 32'd0);
  endtask

  // Reference model updates acc_m and pushes the predicted result before driving the op.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int cdelay, input int hold, output int lat);
    logic [31:0] exp;
    int          hs;
    int          seen;
    exp = acc_m;
    case (f3)
      3'b000: begin exp = acc_m + a * b; acc_m = exp; end
      3'b001: begin exp = acc_m; acc_m = a; end
      3'b010: exp = acc_m;
      default: exp = 32'($countones(a));
    endcase
    exp_q.push_back(exp);
    issue(mk_instr(f3), a, b, cdelay == 0, 1'b0, 1'b1, exp_rr(f3), hs);
    if (cdelay > 0) begin
      for (int i = 1; i < cdelay; i++) begin
        check("no_early_result", {31'd0, xif_result_valid_o}, 32'd0);
        @(negedge clk_i);
      end
      check("no_early_result", {31'd0, xif_result_valid_o}, 32'd0);
      xif_commit_valid_i = 1'b1;
      @(negedge clk_i);
      xif_commit_valid_i = 1'b0;
    end
    collect(hold, seen);
    lat = seen - hs;
  endtask

  task automatic reject(input logic [31:0] instr);
    int hs;
    issue(instr, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 3'b000, hs);
    check("reject_busy", {31'd0, busy_o}, 32'd0);
    check("reject_ready", {31'd0, xif_issue_ready_o}, 32'd1);
    check("reject_valid", {31'd0, xif_result_valid_o}, 32'd0);
  endtask

  initial begin
    int lat;
    int hs;
    int rv_seen;
    rst_ni                  = 1'b0;
    xif_issue_valid_i       = 1'b0;
    xif_issue_req_instr_i   = 32'd0;
    xif_register_rs1_i      = 32'd0;
    xif_register_rs2_i      = 32'd0;
    xif_register_rs3_i      = 32'd0;
    xif_register_rs_valid_i = 3'b111;
    xif_commit_valid_i      = 1'b0;
    xif_commit_kill_i       = 1'b0;
    xif_result_ready_i      = 1'b0;
    acc_m                   = 32'd0;

    repeat (3) @(negedge clk_i);
    check("rst_result_valid", {31'd0, xif_result_valid_o}, 32'd0);
    check("rst_result_we", {31'd0, xif_result_we_o}, 32'd0);
    check("rst_result_data", xif_result_data_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_accept", {31'd0, xif_issue_resp_accept_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", {31'd0, xif_issue_ready_o}, 32'd1);

    // Directed: reset acc read, SWAP then MAC, wrap-around MAC
    do_op(3'b010, 32'd0, 32'd0, 0, 0, lat);
    do_op(3'b001, 32'h5, 32'd0, 0, 0, lat);
    do_op(3'b000, 32'h3, 32'h7, 0, 0, lat);
    check("mac_latency_min", {31'd0, lat >= int'(32 / MulBits)}, 32'd1);
    do_op(3'b010, 32'd0, 32'd0, 0, 0, lat);
    do_op(3'b001, 32'h1, 32'd0, 0, 0, lat);
    do_op(3'b000, 32'hFFFF_FFFF, 32'h2, 0, 0, lat);
    do_op(3'b010, 32'd0, 32'd0, 0, 0, lat);

    // Kill during EXEC: no result, accumulator untouched
    issue(mk_instr(3'b000), 32'h1234, 32'h5678, 1'b0, 1'b0, 1'b1, 3'b011, hs);
    @(negedge clk_i);
    xif_commit_valid_i = 1'b1;
    xif_commit_kill_i  = 1'b1;
    @(negedge clk_i);
    xif_commit_valid_i = 1'b0;
    xif_commit_kill_i  = 1'b0;
    check("kill_busy", {31'd0, busy_o}, 32'd0);
    check("kill_ready", {31'd0, xif_issue_ready_o}, 32'd1);
    rv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (xif_result_valid_o) rv_seen++;
    end
    check("kill_no_result", rv_seen, 32'd0);
    do_op(3'b010, 32'd0, 32'd0, 0, 0, lat);

    // Rejected instructions
    reject(32'h0000_0033);
    reject(32'h0200_000B);
    reject(32'h0000_400B);

    // POPC with back-pressure on the result port
    do_op(3'b011, 32'hF0F0_000F, 32'd0, 0, 5, lat);

    // Commit arriving late, after EXEC has finished
    do_op(3'b010, 32'd0, 32'd0, 3, 0, lat);
    do_op(3'b000, 32'h0000_0100, 32'h0000_0011, 4, 1, lat);
    do_op(3'b001, 32'hDEAD_BEEF, 32'd0, 2, 0, lat);

    // Random mix
    for (int n = 0; n < 10; n++) begin
      do_op(3'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 2), lat);
    end

    // Reset in the middle of a MAC clears the accumulator
    issue(mk_instr(3'b000), 32'h7, 32'h9, 1'b1, 1'b0, 1'b1, 3'b011, hs);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_valid", {31'd0, xif_result_valid_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    acc_m  = 32'd0;
    @(negedge clk_i);
    do_op(3'b010, 32'd0, 32'd0, 0, 0, lat);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
